coin_sprite_gen: RTL and testbench

Generates the coin layer (r_coin/g_coin/b_coin) consumed by the display compositing stage. It places a coin at pseudo-random on-screen positions and detects overlap with the player character once per frame. On overlap it reports a collection, keeps a saturating score, blinks the coin, then respawns it elsewhere. It sits between the VGA timing generator and the colour combiner.

---
 rtl/coin_pkg.sv | 27 ++
 rtl/coin_sprite_gen_if.sv | 26 ++
 rtl/coin_sprite_gen_lfsr16.sv | 25 ++
 rtl/coin_sprite_gen.sv | 161 ++++++++++++++++
 tb/tb_coin_sprite_gen.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coin_pkg.sv
// Shared types for the coin sprite layer: FSM encoding, colours and the
// box-overlap test used both for spawning and for collection.
package coin_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPAWN     = 3'd1,
    PENDING   = 3'd2,
    ACTIVE    = 3'd3,
    COLLECTED = 3'd4
  } coin_state_e;

  localparam logic [2:0] COIN_YELLOW = 3'b110;
  localparam logic [2:0] COIN_WHITE  = 3'b111;
  localparam logic [2:0] BLACK       = 3'b000;

  // Sums are 11 bits wide so a 10-bit coordinate plus an edge never wraps.
  function automatic logic boxes_overlap(
    input logic [10:0] ax, input logic [10:0] ay,
    input logic [10:0] aw, input logic [10:0] ah,
    input logic [10:0] bx, input logic [10:0] by,
    input logic [10:0] bw, input logic [10:0] bh
  );
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

endpackage

// File: rtl/coin_sprite_gen_if.sv
// Signal bundle between timing generator / game logic (master) and the
// coin sprite generator (slave).
interface coin_sprite_gen_if;
  logic       pixel_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       frame_start;
  logic [9:0] char_x;
  logic [9:0] char_y;
  logic       game_en;
  logic       r_coin;
  logic       g_coin;
  logic       b_coin;
  logic       coin_collected;
  logic [7:0] score;

  modport master (
    output pixel_en, hcount, vcount, frame_start, char_x, char_y, game_en,
    input  r_coin, g_coin, b_coin, coin_collected, score
  );

  modport slave (
    input  pixel_en, hcount, vcount, frame_start, char_x, char_y, game_en,
    output r_coin, g_coin, b_coin, coin_collected, score
  );
endinterface

// File: rtl/coin_sprite_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;
  logic        fb;

  // Right-shifting form: taps 16,14,13,11 map to bits 0,2,3,5.
  assign fb  = q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5];
  assign q_d = {fb, q_q[15:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/coin_sprite_gen.sv
// Coin sprite layer: spawns a coin at LFSR positions, detects pickup by the
// character once per frame, keeps a saturating score and blinks on pickup.
//   state     | meaning
//   IDLE      | game stopped, coin hidden
//   SPAWN     | drawing LFSR candidates until one is legal
//   PENDING   | position chosen, waits for blanking to show it
//   ACTIVE    | coin drawn yellow, overlap tested each frame
//   COLLECTED | coin blinks for BLINK_FRAMES frames, then respawns
module coin_sprite_gen
  import coin_pkg::*;
#(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          COIN_SIZE    = 16,
  parameter int          CHAR_SIZE    = 32,
  parameter int          BLINK_FRAMES = 32,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic              clk,
  input logic              rst_n,
  coin_sprite_gen_if.slave bus
);

  localparam int BLINK_W = (BLINK_FRAMES > 8) ? $clog2(BLINK_FRAMES) : 3;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [10:0] COIN_W = 11'(COIN_SIZE);
  localparam logic [10:0] CHAR_W = 11'(CHAR_SIZE);
  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - COIN_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - COIN_SIZE);
  localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);

  logic [15:0]        lfsr;
  coin_state_e        state_q, state_d;
  logic [9:0]         pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [9:0]         coin_x_q, coin_x_d, coin_y_q, coin_y_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic [7:0]         score_q, score_d;
  logic               collected_q, collected_d;
  logic [2:0]         rgb_q, rgb_d;

  logic [10:0] cand_x, cand_y, char_x_w, char_y_w;
  logic [10:0] coin_x_w, coin_y_w, h_w, v_w;
  logic        cand_ok, char_hit, in_box;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  assign cand_x   = {1'b0, lfsr[9:0]};
  assign cand_y   = {2'b00, lfsr[15:7]};
  assign char_x_w = {1'b0, bus.char_x};
  assign char_y_w = {1'b0, bus.char_y};
  assign coin_x_w = {1'b0, coin_x_q};
  assign coin_y_w = {1'b0, coin_y_q};
  assign h_w      = {1'b0, bus.hcount};
  assign v_w      = {1'b0, bus.vcount};

  // A candidate must fit on screen and must not spawn under the character.
  assign cand_ok = (cand_x <= X_MAX) && (cand_y <= Y_MAX) &&
                   !boxes_overlap(cand_x, cand_y, COIN_W, COIN_W,
                                  char_x_w, char_y_w, CHAR_W, CHAR_W);

  assign char_hit = boxes_overlap(coin_x_w, coin_y_w, COIN_W, COIN_W,
                                  char_x_w, char_y_w, CHAR_W, CHAR_W);

  assign in_box = (h_w >= coin_x_w) && (h_w < coin_x_w + COIN_W) &&
                  (v_w >= coin_y_w) && (v_w < coin_y_w + COIN_W) &&
                  (h_w < H_LIM) && (v_w < V_LIM);

  always_comb begin
    state_d     = state_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    coin_x_d    = coin_x_q;
    coin_y_d    = coin_y_q;
    blink_d     = blink_q;
    score_d     = score_q;
    collected_d = 1'b0;
    rgb_d       = rgb_q;

    if (bus.pixel_en) begin
      rgb_d = BLACK;
      if (in_box && state_q == ACTIVE)
        rgb_d = COIN_YELLOW;
      else if (in_box && state_q == COLLECTED && !blink_q[2])
        rgb_d = COIN_WHITE;
    end

    if (!bus.game_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = SPAWN;
        SPAWN: begin
          if (cand_ok) begin
            pend_x_d = cand_x[9:0];
            pend_y_d = cand_y[9:0];
            state_d  = PENDING;
          end
        end
        PENDING: begin
          // Coin moves only at blanking so the frame never tears.
          if (bus.frame_start) begin
            coin_x_d = pend_x_q;
            coin_y_d = pend_y_q;
            state_d  = ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.frame_start && char_hit) begin
            collected_d = 1'b1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
            blink_d = '0;
            state_d = COLLECTED;
          end
        end
        COLLECTED: begin
          if (bus.frame_start) begin
            if (blink_q == BLINK_LAST) state_d = SPAWN;
            else                       blink_d = blink_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      coin_x_q    <= '0;
      coin_y_q    <= '0;
      blink_q     <= '0;
      score_q     <= '0;
      collected_q <= 1'b0;
      rgb_q       <= BLACK;
    end else begin
      state_q     <= state_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      coin_x_q    <= coin_x_d;
      coin_y_q    <= coin_y_d;
      blink_q     <= blink_d;
      score_q     <= score_d;
      collected_q <= collected_d;
      rgb_q       <= rgb_d;
    end
  end

  assign bus.r_coin         = rgb_q[2];
  assign bus.g_coin         = rgb_q[1];
  assign bus.b_coin         = rgb_q[0];
  assign bus.coin_collected = collected_q;
  assign bus.score          = score_q;

endmodule

// File: tb/tb_coin_sprite_gen.sv
// Self-checking bench for coin_sprite_gen: cycle-level game model, pixel
// vector table, and directed sequences for blink, saturation and reset.
module tb_coin_sprite_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  coin_sprite_gen_if bus();

  coin_sprite_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int dut_pulses = 0;

  localparam int M_IDLE = 0, M_SPAWN = 1, M_PEND = 2, M_ACT = 3, M_COL = 4;
  int m_st, m_lfsr, m_px, m_py, m_cx, m_cy, m_blink, m_score, m_rgb, m_col;

  typedef struct { int dh; int dv; int pen; int exp; } pix_vec_t;
  pix_vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dut_rgb();
    return int'({bus.r_coin, bus.g_coin, bus.b_coin});
  endfunction

  function automatic bit hit(input int ax, input int ay, input int as,
                             input int bx, input int by, input int bs);
    return (ax < bx + bs) && (bx < ax + as) && (ay < by + bs) && (by < ay + as);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_lfsr = 'hACE1;
    m_px = 0; m_py = 0; m_cx = 0; m_cy = 0;
    m_blink = 0; m_score = 0; m_rgb = 0; m_col = 0;
  endtask

  // One clock of game behaviour, from the rules written as plain arithmetic.
  task automatic model_step();
    int h, v, cx, cy, fb;
    h = int'(bus.hcount);
    v = int'(bus.vcount);
    if (bus.pixel_en) begin
      m_rgb = 0;
      if (h >= m_cx && h < m_cx + 16 && v >= m_cy && v < m_cy + 16 && h < 640 && v < 480) begin
        if (m_st == M_ACT) m_rgb = 6;
        else if (m_st == M_COL) m_rgb = ((m_blink / 4) % 2 == 0) ? 7 : 0;
      end
    end
    m_col = 0;
    cx = m_lfsr % 1024;
    cy = m_lfsr / 128;
    if (!bus.game_en) m_st = M_IDLE;
    else case (m_st)
      M_IDLE: m_st = M_SPAWN;
      M_SPAWN:
        if (cx <= 624 && cy <= 464 && !hit(cx, cy, 16, int'(bus.char_x), int'(bus.char_y), 32)) begin
          m_px = cx; m_py = cy; m_st = M_PEND;
        end
      M_PEND:
        if (bus.frame_start) begin m_cx = m_px; m_cy = m_py; m_st = M_ACT; end
      M_ACT:
        if (bus.frame_start && hit(m_cx, m_cy, 16, int'(bus.char_x), int'(bus.char_y), 32)) begin
          m_col = 1;
          if (m_score < 255) m_score++;
          m_blink = 0;
          m_st = M_COL;
        end
      M_COL:
        if (bus.frame_start) begin
          if (m_blink == 31) m_st = M_SPAWN;
          else m_blink++;
        end
      default: m_st = M_IDLE;
    endcase
    fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
    m_lfsr = (m_lfsr >> 1) | (fb << 15);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    if (bus.coin_collected) dut_pulses++;
    check("outputs{rgb,pulse,score}", dut_rgb() * 512 + int'(bus.coin_collected) * 256 + int'(bus.score),
          m_rgb * 512 + m_col * 256 + m_score);
  endtask

  task automatic idle(input int n);
    int h, v;
    for (int i = 0; i < n; i++) begin
      bus.frame_start = 1'b0;
      bus.pixel_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        h = int'($urandom_range(0, 1023));
        v = int'($urandom_range(0, 1023));
      end else begin
        h = m_cx + int'($urandom_range(0, 40)) - 12;
        v = m_cy + int'($urandom_range(0, 40)) - 12;
      end
      bus.hcount = h[9:0];
      bus.vcount = v[9:0];
      cyc();
    end
  endtask

  task automatic frame(input int gap);
    bus.frame_start = 1'b1;
    bus.pixel_en = 1'b0;
    cyc();
    bus.frame_start = 1'b0;
    idle(gap);
  endtask

  task automatic fs_cycle();
    bus.frame_start = 1'b1;
    bus.pixel_en = 1'b0;
    cyc();
    bus.frame_start = 1'b0;
  endtask

  task automatic pix_at(input int h, input int v);
    bus.frame_start = 1'b0;
    bus.pixel_en = 1'b1;
    bus.hcount = h[9:0];
    bus.vcount = v[9:0];
    cyc();
    bus.pixel_en = 1'b0;
  endtask

  task automatic wait_pending();
    for (int i = 0; i < 200 && m_st != M_PEND; i++) idle(1);
    if (m_st != M_PEND) check("spawn_timeout", 0, 1);
  endtask

  // Deterministic reset-to-ACTIVE run, so two runs see the same LFSR history.
  task automatic run_start(output int sx, output int sy);
    bus.game_en = 1'b0; bus.char_x = 10'd300; bus.char_y = 10'd200;
    bus.frame_start = 1'b0; bus.pixel_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) cyc();
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_rgb", dut_rgb(), 0);
    check("rst_score", int'(bus.score), 0);
    check("rst_pulse", int'(bus.coin_collected), 0);
    dut_pulses = 0;
    repeat (3) frame(20);
    check("idle_no_pulse", dut_pulses, 0);
    bus.game_en = 1'b1;
    wait_pending();
    sx = m_px;
    sy = m_py;
    pix_at(sx, sy);
    check("pending_hidden", dut_rgb(), 0);
    fs_cycle();
  endtask

  task automatic collect_fast();
    bus.char_x = 10'd700; bus.char_y = 10'd500;
    bus.game_en = 1'b0;
    cyc();
    bus.game_en = 1'b1;
    wait_pending();
    fs_cycle();
    bus.char_x = 10'(m_cx); bus.char_y = 10'(m_cy);
    fs_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s1x, s1y, s2x, s2y, ox, oy, h;

    tbl[0] = '{0, 0, 1, 6};
    tbl[1] = '{40, 0, 0, 6};
    tbl[2] = '{16, 0, 1, 0};
    tbl[3] = '{15, 15, 1, 6};
    tbl[4] = '{0, 16, 1, 0};
    tbl[5] = '{-1, 0, 1, 0};
    tbl[6] = '{0, -1, 1, 0};
    tbl[7] = '{8, 3, 1, 6};
    tbl[8] = '{15, 16, 1, 0};
    tbl[9] = '{16, 15, 1, 0};

    bus.hcount = '0; bus.vcount = '0;
    run_start(s1x, s1y);

    for (int i = 0; i < 10; i++) begin
      bus.frame_start = 1'b0;
      bus.pixel_en = 1'(tbl[i].pen);
      h = m_cx + tbl[i].dh;
      bus.hcount = h[9:0];
      h = m_cy + tbl[i].dv;
      bus.vcount = h[9:0];
      cyc();
      check($sformatf("pix_vec[%0d]", i), dut_rgb(), tbl[i].exp);
    end

    // Edge-adjacent character boxes must not collect; one pixel closer must.
    dut_pulses = 0;
    bus.char_x = 10'(m_cx); bus.char_y = 10'(m_cy + 16);
    frame(3);
    bus.char_x = 10'(m_cx + 16); bus.char_y = 10'(m_cy);
    frame(3);
    check("adjacent_no_pulse", dut_pulses, 0);
    bus.char_x = 10'(m_cx + 15);
    fs_cycle();
    check("overlap_pulse", int'(bus.coin_collected), 1);
    check("overlap_score", int'(bus.score), 1);

    ox = m_cx; oy = m_cy;
    for (int f = 0; f < 32; f++) begin
      pix_at(ox + 4, oy + 4);
      check($sformatf("blink_f%0d", f), dut_rgb(), ((f >> 2) & 1) ? 0 : 7);
      fs_cycle();
    end
    wait_pending();
    fs_cycle();
    pix_at(m_cx, m_cy);
    check("respawn_pix", dut_rgb(), 6);
    if (!hit(ox, oy, 16, m_cx, m_cy, 16)) begin
      pix_at(ox, oy);
      check("old_pos_clear", dut_rgb(), 0);
    end

    // Drop game_en mid-blink: blink abandoned, score held.
    bus.char_x = 10'(m_cx); bus.char_y = 10'(m_cy);
    fs_cycle();
    fs_cycle();
    fs_cycle();
    bus.game_en = 1'b0;
    bus.frame_start = 1'b1;
    pix_at(m_cx + 2, m_cy + 2);
    bus.frame_start = 1'b0;
    check("abandon_score", int'(bus.score), 2);
    check("abandon_last_white", dut_rgb(), 7);
    pix_at(m_cx + 2, m_cy + 2);
    check("idle_blank", dut_rgb(), 0);

    for (int i = 0; i < 300 && m_score < 255; i++) collect_fast();
    check("sat_reached", int'(bus.score), 255);
    collect_fast();
    check("sat_pulse", int'(bus.coin_collected), 1);
    check("sat_hold", int'(bus.score), 255);

    // Asynchronous reset between clock edges while blinking white.
    pix_at(m_cx + 1, m_cy + 1);
    check("pre_reset_white", dut_rgb(), 7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rgb", dut_rgb(), 0);
    check("async_score", int'(bus.score), 0);
    check("async_pulse", int'(bus.coin_collected), 0);

    run_start(s2x, s2y);
    pix_at(s1x, s1y);
    check("replay_pix", dut_rgb(), 6);
    pix_at(s1x + 16, s1y);
    check("replay_edge", dut_rgb(), 0);

    // game_en low outranks a frame_start that would otherwise collect.
    bus.char_x = 10'(m_cx); bus.char_y = 10'(m_cy);
    bus.game_en = 1'b0;
    fs_cycle();
    check("prio_no_pulse", int'(bus.coin_collected), 0);
    check("prio_score", int'(bus.score), 0);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
